camera_frame_transmitter: RTL and testbench

Upstream stage of the inter-camera UART link. It runs on the camera-2 FPGA, takes one pair of 12-bit hand coordinates (top and bottom marker), and packs them into a 9-byte frame: a 3-byte 0xFF sync preamble followed by 6 payload bytes. It serialises the frame as 8N1 UART on a single pin that drives the camera-1 receiver's jc[0] input. Coordinates are clamped so the payload can never reproduce the sync pattern.

---
 rtl/cam_link_pkg.sv | 18 +
 rtl/uart_tx_byte.sv | 90 +++++++++
 rtl/camera_frame_transmitter.sv | 111 +++++++++++
 tb/tb_camera_frame_transmitter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/cam_link_pkg.sv
// Shared definitions for the inter-camera UART link, used by both the camera-2
// transmitter and the camera-1 receiver.
package cam_link_pkg;

  localparam logic [7:0] SYNC_BYTE   = 8'hFF;
  localparam int         SYNC_LEN    = 3;
  localparam int         FRAME_BYTES = 9;
  localparam int         COORD_W     = 12;
  localparam logic [COORD_W-1:0] COORD_MAX = 12'hEFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } frame_state_e;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser: one start bit, eight data bits LSB first, one stop bit,
// each held for BAUD_DIV clocks. A start in the final stop cycle chains bytes.
module uart_tx_byte
  import cam_link_pkg::*;
#(
  parameter int BAUD_DIV = 564
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] byte_in,
  output logic       done,
  output logic       tx
);

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

  frame_state_e state_q, state_d;
  logic [15:0]  baud_q, baud_d;
  logic [2:0]   bit_q, bit_d;
  logic [7:0]   shift_q, shift_d;
  logic         tx_q, tx_d;
  logic         wrap;

  assign wrap = (baud_q == BAUD_LAST);
  assign tx   = tx_q;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    done    = 1'b0;
    if (state_q != ST_IDLE) baud_d = wrap ? 16'd0 : baud_q + 16'd1;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_START;
        baud_d  = 16'd0;
        shift_d = byte_in;
        tx_d    = 1'b0;
      end
      ST_START: if (wrap) begin
        state_d = ST_DATA;
        bit_d   = 3'd0;
        tx_d    = shift_q[0];
        shift_d = {1'b0, shift_q[7:1]};
      end
      ST_DATA: if (wrap) begin
        if (bit_q == 3'd7) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end else begin
          bit_d   = bit_q + 3'd1;
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
        end
      end
      ST_STOP: if (wrap) begin
        done = 1'b1;
        // Chaining straight into the next start bit keeps bytes gap-free
        if (start) begin
          state_d = ST_START;
          shift_d = byte_in;
          tx_d    = 1'b0;
        end else begin
          state_d = ST_IDLE;
          tx_d    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    if (rst) begin
      state_q <= ST_IDLE;
      baud_q  <= 16'd0;
      bit_q   <= 3'd0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: rtl/camera_frame_transmitter.sv
// Packs one clamped pair of hand coordinates behind a 3-byte 0xFF preamble and
// streams the 9-byte frame through uart_tx_byte.
module camera_frame_transmitter
  import cam_link_pkg::*;
#(
  parameter int BAUD_DIV = 564
) (
  input  logic               clk_65mhz,
  input  logic               sys_rst,
  input  logic               coord_valid,
  output logic               coord_ready,
  input  logic [COORD_W-1:0] hand_x_top,
  input  logic [COORD_W-1:0] hand_y_top,
  input  logic [COORD_W-1:0] hand_x_bottom,
  input  logic [COORD_W-1:0] hand_y_bottom,
  output logic               tx_out,
  output logic               busy,
  output logic               frame_done
);

  // Capping at 0xEFF keeps every payload byte from forming a 3x0xFF run
  function automatic logic [COORD_W-1:0] clamp_coord(input logic [COORD_W-1:0] v);
    return (v > COORD_MAX) ? COORD_MAX : v;
  endfunction

  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;
  logic [3:0]         byte_idx_q, byte_idx_d;
  logic [COORD_W-1:0] xt_q, yt_q, xb_q, yb_q;
  logic [COORD_W-1:0] xt_d, yt_d, xb_d, yb_d;
  logic [3:0]         sel_idx;
  logic [7:0]         tx_byte;
  logic               byte_start, byte_done, tx_raw, handshake;

  assign coord_ready = ~busy_q & ~sys_rst;
  assign handshake   = coord_valid & coord_ready;
  assign busy        = busy_q & ~sys_rst;
  assign frame_done  = frame_done_q & ~sys_rst;
  assign tx_out      = tx_raw | sys_rst;

  always_comb begin
    busy_d       = busy_q;
    byte_idx_d   = byte_idx_q;
    frame_done_d = 1'b0;
    xt_d         = xt_q;
    yt_d         = yt_q;
    xb_d         = xb_q;
    yb_d         = yb_q;
    byte_start   = 1'b0;
    sel_idx      = byte_idx_q + 4'd1;
    if (handshake) begin
      busy_d     = 1'b1;
      byte_idx_d = 4'd0;
      byte_start = 1'b1;
      sel_idx    = 4'd0;
      xt_d       = clamp_coord(hand_x_top);
      yt_d       = clamp_coord(hand_y_top);
      xb_d       = clamp_coord(hand_x_bottom);
      yb_d       = clamp_coord(hand_y_bottom);
    end else if (busy_q && byte_done) begin
      if (byte_idx_q < 4'(FRAME_BYTES - 1)) begin
        byte_idx_d = byte_idx_q + 4'd1;
        byte_start = 1'b1;
      end else begin
        busy_d       = 1'b0;
        frame_done_d = 1'b1;
      end
    end
  end

  always_comb begin
    tx_byte = SYNC_BYTE;
    if (sel_idx >= 4'(SYNC_LEN)) begin
      case (sel_idx)
        4'd3:    tx_byte = xt_q[11:4];
        4'd4:    tx_byte = yt_q[7:0];
        4'd5:    tx_byte = {xt_q[3:0], yt_q[11:8]};
        4'd6:    tx_byte = xb_q[11:4];
        4'd7:    tx_byte = yb_q[7:0];
        4'd8:    tx_byte = {xb_q[3:0], yb_q[11:8]};
        default: tx_byte = SYNC_BYTE;
      endcase
    end
  end

  always_ff @(posedge clk_65mhz) begin
    xt_q <= xt_d;
    yt_q <= yt_d;
    xb_q <= xb_d;
    yb_q <= yb_d;
    if (sys_rst) begin
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      byte_idx_q   <= 4'd0;
    end else begin
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      byte_idx_q   <= byte_idx_d;
    end
  end

  uart_tx_byte #(.BAUD_DIV(BAUD_DIV)) u_tx (
    .clk     (clk_65mhz),
    .rst     (sys_rst),
    .start   (byte_start),
    .byte_in (tx_byte),
    .done    (byte_done),
    .tx      (tx_raw)
  );

endmodule

// File: tb/tb_camera_frame_transmitter.sv
// Directed + randomized bench: records the serial line cycle by cycle and
// decodes frames against a byte-level model of the frame format.
module tb_camera_frame_transmitter;

  localparam int BD    = 4;
  localparam int FLEN  = 90 * BD;
  localparam int DEPTH = 1200;

  logic        clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        coord_valid = 1'b0;
  logic        coord_ready;
  logic [11:0] hand_x_top = '0, hand_y_top = '0, hand_x_bottom = '0, hand_y_bottom = '0;
  logic        tx_out, busy, frame_done;

  int checks = 0;
  int failures = 0;

  logic tx_r   [DEPTH];
  logic fd_r   [DEPTH];
  logic busy_r [DEPTH];
  logic rdy_r  [DEPTH];
  logic [7:0] exp_b [9];
  logic [7:0] dec_b [9];
  logic [11:0] pat_base [4];
  int pat_stop;

  camera_frame_transmitter #(.BAUD_DIV(BD)) dut (
    .clk_65mhz     (clk),
    .sys_rst       (sys_rst),
    .coord_valid   (coord_valid),
    .coord_ready   (coord_ready),
    .hand_x_top    (hand_x_top),
    .hand_y_top    (hand_y_top),
    .hand_x_bottom (hand_x_bottom),
    .hand_y_bottom (hand_y_bottom),
    .tx_out        (tx_out),
    .busy          (busy),
    .frame_done    (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [11:0] sat(input logic [11:0] v);
    return (v > 12'hEFF) ? 12'hEFF : v;
  endfunction

  task automatic build_exp(input logic [11:0] xt, input logic [11:0] yt,
                           input logic [11:0] xb, input logic [11:0] yb);
    logic [11:0] cxt, cyt, cxb, cyb;
    cxt = sat(xt); cyt = sat(yt); cxb = sat(xb); cyb = sat(yb);
    exp_b[0] = 8'hFF; exp_b[1] = 8'hFF; exp_b[2] = 8'hFF;
    exp_b[3] = cxt[11:4];
    exp_b[4] = cyt[7:0];
    exp_b[5] = {cxt[3:0], cyt[11:8]};
    exp_b[6] = cxb[11:4];
    exp_b[7] = cyb[7:0];
    exp_b[8] = {cxb[3:0], cyb[11:8]};
  endtask

  function automatic logic [11:0] patv(input int n, input int c);
    return pat_base[c] + 12'(n * (2 * c + 3));
  endfunction

  // mode 0: inputs untouched; 1: drop valid after first sample; 2: pattern drive
  task automatic capture(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tx_r[i] = tx_out; fd_r[i] = frame_done; busy_r[i] = busy; rdy_r[i] = coord_ready;
      if (mode == 1) coord_valid = 1'b0;
      if (mode == 2) begin
        coord_valid   = (i < pat_stop);
        hand_x_top    = patv(i, 0);
        hand_y_top    = patv(i, 1);
        hand_x_bottom = patv(i, 2);
        hand_y_bottom = patv(i, 3);
      end
    end
  endtask

  task automatic check_frame(input int s, input string tag);
    logic [7:0] d;
    logic bitv;
    int base, bad_frm, bad_stab, fd_early, ffcnt, ffpos;
    bad_frm = 0; bad_stab = 0; fd_early = 0; ffcnt = 0; ffpos = -1;
    d = '0;
    for (int j = 0; j < 9; j++) begin
      for (int k = 0; k < 10; k++) begin
        base = s + (10 * j + k) * BD;
        bitv = tx_r[base + BD / 2];
        for (int m = 0; m < BD; m++) if (tx_r[base + m] !== bitv) bad_stab++;
        if (k == 0) begin
          if (bitv !== 1'b0) bad_frm++;
        end else if (k == 9) begin
          if (bitv !== 1'b1) bad_frm++;
        end else d[k-1] = bitv;
      end
      dec_b[j] = d;
    end
    for (int j = 0; j < 9; j++) chk($sformatf("%s_byte%0d", tag, j), 32'(dec_b[j]), 32'(exp_b[j]));
    chk({tag, "_framing"}, bad_frm, 0);
    chk({tag, "_bit_width"}, bad_stab, 0);
    for (int i = s; i < s + FLEN; i++) if (fd_r[i] !== 1'b0) fd_early++;
    chk({tag, "_done_early"}, fd_early, 0);
    chk({tag, "_done_at_end"}, 32'(fd_r[s + FLEN]), 1);
    chk({tag, "_busy_at_end"}, 32'(busy_r[s + FLEN]), 0);
    chk({tag, "_ready_at_end"}, 32'(rdy_r[s + FLEN]), 1);
    chk({tag, "_busy_mid"}, 32'(busy_r[s + FLEN / 2]), 1);
    for (int o = 0; o <= 6; o++)
      if (dec_b[o] == 8'hFF && dec_b[o+1] == 8'hFF && dec_b[o+2] == 8'hFF) begin
        ffcnt++;
        if (ffpos < 0) ffpos = o;
      end
    chk({tag, "_sync_count"}, ffcnt, 1);
    chk({tag, "_sync_pos"}, ffpos, 0);
  endtask

  task automatic send_one(input logic [11:0] xt, input logic [11:0] yt,
                          input logic [11:0] xb, input logic [11:0] yb, input string tag);
    @(negedge clk);
    chk({tag, "_ready_before"}, 32'(coord_ready), 1);
    coord_valid = 1'b1;
    hand_x_top = xt; hand_y_top = yt; hand_x_bottom = xb; hand_y_bottom = yb;
    build_exp(xt, yt, xb, yb);
    capture(FLEN + 4, 1);
    check_frame(0, tag);
  endtask

  initial begin
    int zeros;
    logic [11:0] r [4];

    // Reset behaviour
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx_out), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(frame_done), 0);
    chk("rst_ready", 32'(coord_ready), 0);
    sys_rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(coord_ready), 1);
    chk("post_rst_tx", 32'(tx_out), 1);
    chk("post_rst_busy", 32'(busy), 0);
    capture(100, 0);
    zeros = 0;
    for (int i = 0; i < 100; i++) if (tx_r[i] !== 1'b1) zeros++;
    chk("idle_line_quiet", zeros, 0);

    // Directed frame
    send_one(12'h123, 12'h456, 12'h789, 12'h0AB, "directed");
    // Saturating frame
    send_one(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, "clamp");

    // Random frames
    for (int f = 0; f < 3; f++) begin
      for (int c = 0; c < 4; c++) r[c] = 12'($urandom);
      if (f == 0) r[0] = 12'($urandom_range(12'hFFF, 12'hEF0));
      send_one(r[0], r[1], r[2], r[3], $sformatf("rand%0d", f));
    end

    // Continuous valid: three back-to-back frames with a one-cycle gap
    for (int c = 0; c < 4; c++) pat_base[c] = 12'($urandom);
    pat_base[0] = 12'($urandom_range(12'hFFF, 12'hE00));
    pat_stop = 3 * (FLEN + 1);
    capture(3 * (FLEN + 1) + 8, 2);
    coord_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      build_exp(patv(k * (FLEN + 1), 0), patv(k * (FLEN + 1), 1),
                patv(k * (FLEN + 1), 2), patv(k * (FLEN + 1), 3));
      check_frame(1 + k * (FLEN + 1), $sformatf("stream%0d", k));
      chk($sformatf("stream%0d_gap_high", k), 32'(tx_r[(k + 1) * (FLEN + 1)]), 1);
    end
    zeros = 0;
    for (int i = 3 * (FLEN + 1) + 1; i < 3 * (FLEN + 1) + 8; i++) if (tx_r[i] !== 1'b1) zeros++;
    chk("stream_no_extra_frame", zeros, 0);

    // Reset during byte 4, data bit 3
    @(negedge clk);
    coord_valid = 1'b1;
    hand_x_top = 12'h3C5; hand_y_top = 12'h0F7; hand_x_bottom = 12'h111; hand_y_bottom = 12'h222;
    capture(4 * 10 * BD + 4 * BD + 2, 1);
    chk("abort_bit_before", 32'(tx_r[4 * 10 * BD + 4 * BD + 1]), 32'(hand_y_top[3]));
    sys_rst = 1'b1;
    @(negedge clk);
    chk("abort_tx", 32'(tx_out), 1);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(frame_done), 0);
    @(negedge clk);
    sys_rst = 1'b0;
    capture(FLEN + 20, 0);
    zeros = 0;
    for (int i = 0; i < FLEN + 20; i++) if (tx_r[i] !== 1'b1 || fd_r[i] !== 1'b0) zeros++;
    chk("abort_line_quiet", zeros, 0);
    for (int c = 0; c < 4; c++) r[c] = 12'($urandom);
    send_one(r[0], r[1], r[2], r[3], "after_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
